// File: rtl/verifier_check_eval_c012.sv
// Sumcheck verifier round consumer: checks f(0)+f(1) against the previous
// claim and evaluates f(tau) by Horner's rule, sharing one modular adder and
// one serial modular multiplier under a small sequencing FSM.

`ifndef F_NBITS
`define F_NBITS 32
`endif
`ifndef F_PRIME
`define F_PRIME 32'hFFFF_FFFB
`endif

// Single-cycle modular adder: result and ready_pulse appear the cycle after en.
module field_adder (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic                ready_pulse,
    output logic [`F_NBITS-1:0] sum
);
    localparam int W = `F_NBITS;
    localparam logic [W-1:0] P = `F_PRIME;

    logic [W:0]   raw;
    logic [W-1:0] reduced;

    // One conditional subtraction suffices because both operands are below p.
    always_comb begin
        raw     = {1'b0, a} + {1'b0, b};
        reduced = (raw >= {1'b0, P}) ? (raw[W-1:0] - P) : raw[W-1:0];
    end

    // Capture the sum on a launch and flag completion one cycle later.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready_pulse <= 1'b0;
            sum         <= '0;
        end else begin
            ready_pulse <= en;
            if (en) begin
                sum <= reduced;
            end
        end
    end
endmodule

// Serial double-and-add modular multiplier, one bit of b per cycle, MSB first.
module field_multiplier (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic                ready,
    output logic                ready_pulse,
    output logic [`F_NBITS-1:0] prod
);
    localparam int W  = `F_NBITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] P = `F_PRIME;

    logic [CW-1:0] cnt;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W:0]    dbl;
    logic [W-1:0]  dbl_red;
    logic [W-1:0]  addend;
    logic [W:0]    acc_sum;
    logic [W-1:0]  step;

    // One iteration: acc = 2*acc + bit*a, each partial result kept below p.
    always_comb begin
        dbl     = {prod, 1'b0};
        dbl_red = (dbl >= {1'b0, P}) ? (dbl[W-1:0] - P) : dbl[W-1:0];
        addend  = b_r[W-1] ? a_r : '0;
        acc_sum = {1'b0, dbl_red} + {1'b0, addend};
        step    = (acc_sum >= {1'b0, P}) ? (acc_sum[W-1:0] - P) : acc_sum[W-1:0];
    end

    // Launch clears the accumulator; ready stays low until all bits are consumed.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            prod        <= '0;
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
        end else begin
            ready_pulse <= 1'b0;
            if (en) begin
                a_r   <= a;
                b_r   <= b;
                prod  <= '0;
                cnt   <= CW'(W);
                ready <= 1'b0;
            end else if (!ready) begin
                prod <= step;
                b_r  <= b_r << 1;
                cnt  <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    ready       <= 1'b1;
                    ready_pulse <= 1'b1;
                end
            end
        end
    end
endmodule

module verifier_check_eval_c012 (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [`F_NBITS-1:0] c [3],
    input  logic [`F_NBITS-1:0] prev,
    input  logic [`F_NBITS-1:0] tau,
    output logic                ready,
    output logic                ready_pulse,
    output logic                ok,
    output logic [`F_NBITS-1:0] eval
);
    localparam int W = `F_NBITS;

    typedef enum logic [3:0] {
        IDLE, A0, A1, A2, CMP, A3, M1, A4, DONE
    } state_t;

    state_t       state, next_state;
    logic         issued, next_issued;
    logic         en_dly, ready_dly, start;

    logic         add_en, add_rp;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         mul_en, mul_ready, mul_rp;
    logic [W-1:0] mul_a, mul_b, m;

    logic [W-1:0] c0_r, c1_r, c2_r, prev_r, tau_r;
    logic [W-1:0] t, h;
    logic         sum_ok;

    field_adder u_add (
        .clk         (clk),
        .rstb        (rstb),
        .en          (add_en),
        .a           (add_a),
        .b           (add_b),
        .ready_pulse (add_rp),
        .sum         (add_sum)
    );

    field_multiplier u_mul (
        .clk         (clk),
        .rstb        (rstb),
        .en          (mul_en),
        .a           (mul_a),
        .b           (mul_b),
        .ready       (mul_ready),
        .ready_pulse (mul_rp),
        .prod        (m)
    );

    // State register plus the "unit op already launched" flag for the current state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= IDLE;
            issued <= 1'b0;
        end else begin
            state  <= next_state;
            issued <= next_issued;
        end
    end

    // Sequencing: each op state launches its unit once, then waits for its pulse.
    always_comb begin
        next_state  = state;
        next_issued = issued;
        start       = 1'b0;
        add_en      = 1'b0;
        add_a       = '0;
        add_b       = '0;
        mul_en      = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        ready       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (en && !en_dly) begin
                    start       = 1'b1;
                    next_state  = A0;
                    next_issued = 1'b0;
                end
            end
            A0: begin
                add_a = c0_r;
                add_b = c1_r;
                mul_a = c2_r;
                mul_b = tau_r;
                if (!issued) begin
                    add_en      = 1'b1;
                    mul_en      = 1'b1;
                    next_issued = 1'b1;
                end else if (add_rp) begin
                    next_state  = A1;
                    next_issued = 1'b0;
                end
            end
            A1: begin
                add_a = t;
                add_b = c2_r;
                if (!issued) begin
                    add_en      = 1'b1;
                    next_issued = 1'b1;
                end else if (add_rp) begin
                    next_state  = A2;
                    next_issued = 1'b0;
                end
            end
            A2: begin
                add_a = t;
                add_b = c0_r;
                if (!issued) begin
                    add_en      = 1'b1;
                    next_issued = 1'b1;
                end else if (add_rp) begin
                    next_state  = CMP;
                    next_issued = 1'b0;
                end
            end
            CMP: begin
                next_state = A3;
            end
            A3: begin
                add_a = m;
                add_b = c1_r;
                if (!issued) begin
                    if (mul_ready) begin
                        add_en      = 1'b1;
                        next_issued = 1'b1;
                    end
                end else if (add_rp) begin
                    next_state  = M1;
                    next_issued = 1'b0;
                end
            end
            M1: begin
                mul_a = h;
                mul_b = tau_r;
                if (!issued) begin
                    mul_en      = 1'b1;
                    next_issued = 1'b1;
                end else if (mul_rp) begin
                    next_state  = A4;
                    next_issued = 1'b0;
                end
            end
            A4: begin
                add_a = h;
                add_b = c0_r;
                if (!issued) begin
                    add_en      = 1'b1;
                    next_issued = 1'b1;
                end else if (add_rp) begin
                    next_state  = DONE;
                    next_issued = 1'b0;
                end
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state  = IDLE;
                next_issued = 1'b0;
            end
        endcase
        ready_pulse = ready & ~ready_dly;
    end

    // Operand latches, temporaries and results; ok/eval change only on entry to DONE.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            en_dly    <= 1'b1;
            ready_dly <= 1'b1;
            c0_r      <= '0;
            c1_r      <= '0;
            c2_r      <= '0;
            prev_r    <= '0;
            tau_r     <= '0;
            t         <= '0;
            h         <= '0;
            sum_ok    <= 1'b0;
            ok        <= 1'b0;
            eval      <= '0;
        end else begin
            en_dly    <= en;
            ready_dly <= ready;
            if (start) begin
                c0_r   <= c[0];
                c1_r   <= c[1];
                c2_r   <= c[2];
                prev_r <= prev;
                tau_r  <= tau;
            end
            if ((state == A0 || state == A1 || state == A2) && issued && add_rp) begin
                t <= add_sum;
            end
            if (state == CMP) begin
                sum_ok <= (t == prev_r);
            end
            if (state == A3 && issued && add_rp) begin
                h <= add_sum;
            end
            if (state == M1 && issued && mul_rp) begin
                h <= m;
            end
            if (state == A4 && issued && add_rp) begin
                eval <= add_sum;
                ok   <= sum_ok;
            end
        end
    end
endmodule
